// File: rtl/map_hub_sync.sv
// map_hub_sync: picks the mapper channel serving map_idx and drives its bundle on map_out, with a guarded HOLD on every channel switch (in: clk, rst, map_idx, idx_tab, map_in, safe_out; out: map_out, sel_ch, busy, map_rst, sw_cnt)
module map_hub_sync #(
  parameter int CH = 8,
  parameter int OW = 64,
  parameter int IW = 10,
  parameter int GUARD = 4,
  parameter int SW = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    map_idx,
  input  logic [CH*IW-1:0] idx_tab,
  input  logic [CH*OW-1:0] map_in,
  input  logic [OW-1:0]    safe_out,
  output logic [OW-1:0]    map_out,
  output logic [SW-1:0]    sel_ch,
  output logic             busy,
  output logic             map_rst,
  output logic [7:0]       sw_cnt
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] lk, sel_d;
  logic [7:0] gcnt, gcnt_d, cnt_d;
  logic [OW-1:0] out_d, cur;
  logic [OW-1:0] ch_data [CH];
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign ch_data[g] = map_in[g*OW +: OW];
  end
  assign cur = ch_data[sel_ch];
  assign busy = state == HOLD;
  assign map_rst = busy;
  always_comb begin
    lk = '0;
    for (int c = CH - 1; c >= 0; c--)
      if (idx_tab[c*IW +: IW] == idx_q) lk = SW'(c);
  end
  always_comb begin
    state_d = state;
    sel_d = sel_ch;
    gcnt_d = gcnt;
    cnt_d = sw_cnt;
    out_d = safe_out;
    if (lk != sel_ch) begin
      state_d = HOLD;
      sel_d = lk;
      gcnt_d = 8'(GUARD - 1);
    end else if (state == RUN) begin
      out_d = cur;
    end else if (gcnt != 8'd0) begin
      gcnt_d = gcnt - 8'd1;
    end else begin
      state_d = RUN;
      out_d = cur;
      cnt_d = sw_cnt + {7'd0, sw_cnt != 8'hFF};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      sel_ch <= '0;
      gcnt <= '0;
      idx_q <= '0;
      map_out <= '0;
      sw_cnt <= '0;
    end else begin
      state <= state_d;
      sel_ch <= sel_d;
      gcnt <= gcnt_d;
      idx_q <= map_idx;
      map_out <= out_d;
      sw_cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_map_hub_sync.sv
// tb_map_hub_sync: scoreboard bench for map_hub_sync with directed timing, re-request, no-match, reset and saturation checks
module tb_map_hub_sync;
  localparam int CH = 8, OW = 64, IW = 10, GUARD = 4, SW = 3;
  logic clk = 0;
  logic rst;
  logic [IW-1:0] map_idx;
  logic [CH*IW-1:0] idx_tab;
  logic [CH*OW-1:0] map_in;
  logic [OW-1:0] safe_out = 64'hDEAD_BEEF_0BAD_F00D;
  logic [OW-1:0] map_out;
  logic [SW-1:0] sel_ch;
  logic busy, map_rst;
  logic [7:0] sw_cnt;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [OW-1:0] out;
    logic [SW-1:0] sel;
    logic busy;
    logic [7:0] cnt;
  } exp_t;
  exp_t sbq [$];
  logic [IW-1:0] m_q;
  logic [SW-1:0] m_sel;
  logic m_hold;
  logic [7:0] m_g, m_cnt;
  logic [OW-1:0] m_out;
  map_hub_sync #(.CH(CH), .OW(OW), .IW(IW), .GUARD(GUARD), .SW(SW)) dut (
    .clk(clk), .rst(rst), .map_idx(map_idx), .idx_tab(idx_tab), .map_in(map_in),
    .safe_out(safe_out), .map_out(map_out), .sel_ch(sel_ch), .busy(busy),
    .map_rst(map_rst), .sw_cnt(sw_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [SW-1:0] lookup(input logic [IW-1:0] v);
    int c = 0;
    while (c < CH && idx_tab[c*IW +: IW] != v) c++;
    return (c < CH) ? SW'(c) : '0;
  endfunction
  task automatic drive_data();
    for (int c = 0; c < CH; c++) map_in[c*OW +: OW] = {$urandom, $urandom};
    map_in[3*OW +: OW] = 64'hA5 + 64'(cyc);
  endtask
  task automatic step();
    exp_t e;
    logic [SW-1:0] lk;
    if (rst) begin
      m_q = '0; m_sel = '0; m_hold = 0; m_g = '0; m_out = '0; m_cnt = '0;
    end else begin
      lk = lookup(m_q);
      m_q = map_idx;
      if (lk != m_sel) begin
        m_hold = 1; m_sel = lk; m_g = 8'(GUARD - 1); m_out = safe_out;
      end else if (!m_hold) begin
        m_out = map_in[m_sel*OW +: OW];
      end else if (m_g > 0) begin
        m_g--; m_out = safe_out;
      end else begin
        m_hold = 0; m_out = map_in[m_sel*OW +: OW];
        if (m_cnt < 8'd255) m_cnt++;
      end
    end
    e.out = m_out; e.sel = m_sel; e.busy = m_hold; e.cnt = m_cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sbq.pop_front();
    chk("map_out", map_out, e.out);
    chk("sel_ch", 64'(sel_ch), 64'(e.sel));
    chk("busy", 64'(busy), 64'(e.busy));
    chk("map_rst", 64'(map_rst), 64'(e.busy));
    chk("sw_cnt", 64'(sw_cnt), 64'(e.cnt));
    drive_data();
  endtask
  initial begin
    logic [5:0] pat;
    logic [7:0] c0;
    logic [OW-1:0] prev3;
    idx_tab = '0;
    idx_tab[0*IW +: IW] = 10'd100;
    idx_tab[1*IW +: IW] = 10'd261;
    idx_tab[2*IW +: IW] = 10'd290;
    idx_tab[3*IW +: IW] = 10'd4;
    idx_tab[4*IW +: IW] = 10'd500;
    idx_tab[5*IW +: IW] = 10'd290;
    idx_tab[6*IW +: IW] = 10'd600;
    idx_tab[7*IW +: IW] = 10'd700;
    rst = 1;
    map_idx = '0;
    drive_data();
    repeat (3) step();
    chk("rst_out", map_out, 64'd0);
    chk("rst_sel", 64'(sel_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(sw_cnt), 64'd0);
    rst = 0;
    map_idx = 10'd4;
    repeat (10) step();
    chk("steady_sel", 64'(sel_ch), 64'd3);
    chk("steady_busy", 64'(busy), 64'd0);
    prev3 = map_in[3*OW +: OW];
    step();
    chk("steady_lat", map_out, prev3);
    map_idx = 10'd261;
    pat = 6'b011110;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("sw_busy_t", 64'(busy), 64'(pat[k]));
      if (pat[k]) chk("sw_safe_t", map_out, safe_out);
    end
    chk("sw_sel", 64'(sel_ch), 64'd1);
    chk("sw_cnt2", 64'(sw_cnt), 64'd2);
    map_idx = 10'd4;
    repeat (10) step();
    c0 = sw_cnt;
    map_idx = 10'd261;
    repeat (2) step();
    map_idx = 10'd290;
    repeat (12) step();
    chk("rereq_sel", 64'(sel_ch), 64'd2);
    chk("rereq_cnt", 64'(sw_cnt), 64'(c0 + 8'd1));
    map_idx = 10'd999;
    repeat (10) step();
    chk("nomatch_sel", 64'(sel_ch), 64'd0);
    chk("nomatch_busy", 64'(busy), 64'd0);
    map_idx = 10'd261;
    repeat (3) step();
    chk("mid_hold", 64'(busy), 64'd1);
    rst = 1;
    step();
    chk("rh_out", map_out, 64'd0);
    chk("rh_sel", 64'(sel_ch), 64'd0);
    chk("rh_busy", 64'(busy), 64'd0);
    chk("rh_mrst", 64'(map_rst), 64'd0);
    chk("rh_cnt", 64'(sw_cnt), 64'd0);
    rst = 0;
    repeat (10) step();
    chk("post_rst_sel", 64'(sel_ch), 64'd1);
    for (int i = 0; i < 300; i++) begin
      map_idx = (i % 2) ? 10'd290 : 10'd4;
      repeat (8) step();
    end
    chk("sat_cnt", 64'(sw_cnt), 64'd255);
    chk("dup_sel", 64'(sel_ch), 64'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/map_hub_sync.md
MAP_HUB_SYNC -- requirements
Module: map_hub_sync

Interface
REQ-001 SHALL have parameter CH, default 8: number of mapper channels, 2..32.
REQ-002 SHALL have parameter OW, default 64: width of one mapper output bundle.
REQ-003 SHALL have parameter IW, default 10: mapper index width.
REQ-004 SHALL have parameter GUARD, default 4: hold length in cycles on a channel switch, 1..255.
REQ-005 SHALL have parameter SW, default $clog2(CH): channel select width.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 map_idx  input  IW  requested mapper number from system config.
REQ-009 idx_tab  input  CH*IW  mapper number served by each channel; channel c occupies bits [c*IW +: IW].
REQ-010 map_in  input  CH*OW  output bundle of each mapper; channel c occupies bits [c*OW +: OW].
REQ-011 safe_out  input  OW  idle bundle driven during a switch.
REQ-012 map_out  output  OW  registered selected bundle.
REQ-013 sel_ch  output  SW  currently committed channel.
REQ-014 busy  output  1  high while in HOLD.
REQ-015 map_rst  output  1  reset to mappers, high while in HOLD.
REQ-016 sw_cnt  output  8  saturating count of completed switches.

Function
REQ-017 SHALL register map_idx into idx_q every cycle.
REQ-018 SHALL compute lookup channel lk from idx_q: lowest c with idx_tab[c] == idx_q; lk = 0 when nothing matches; channel 0 is the nominal fallback.
REQ-019 SHALL implement states RUN and HOLD, plus an 8-bit down-counter gcnt.
REQ-020 In RUN with lk == sel_ch: map_out <= map_in[sel_ch]; gives one-cycle latency from map_in to map_out.
REQ-021 In RUN with lk != sel_ch: next state HOLD; sel_ch <= lk; gcnt <= GUARD-1; map_out <= safe_out; busy and map_rst go to 1 on the same edge.
REQ-022 In HOLD: map_out <= safe_out every cycle; busy = map_rst = 1.
REQ-023 In HOLD with lk != sel_ch (re-request): sel_ch <= lk; gcnt <= GUARD-1; stay in HOLD; sw_cnt does not increment.
REQ-024 In HOLD with lk == sel_ch and gcnt != 0: gcnt <= gcnt-1.
REQ-025 In HOLD with lk == sel_ch and gcnt == 0: next state RUN; busy and map_rst go to 0; map_out <= map_in[sel_ch]; sw_cnt increments, saturating at 255.
REQ-026 HOLD SHALL last exactly GUARD cycles after the last sel_ch change; with GUARD = 1 it lasts one cycle.
REQ-027 A map_idx change SHALL first show on busy 2 edges later: 1 for idx_q, 1 for the state register.
REQ-028 Duplicate idx_tab entries SHALL resolve to the lowest channel.
REQ-029 map_out SHALL never carry bundle data from a channel other than sel_ch.
REQ-030 map_out SHALL never carry a mix of two channels' bits.

Reset
REQ-031 On rst = 1 at an edge: state = RUN, sel_ch = 0, gcnt = 0, idx_q = 0, map_out = 0, busy = 0, map_rst = 0, sw_cnt = 0.
REQ-032 rst SHALL override any HOLD in progress; no sw_cnt increment for an aborted HOLD.
REQ-033 After rst release, if lk of idx_q = 0 is not 0, a normal switch sequence SHALL follow.

Verification
REQ-034 Steady select:
- Setup: CH=8, idx_tab[3]=4, map_idx=4 held, map_in[3]=0xA5 changing each cycle.
- Response: after the switch completes, map_out equals map_in[3] delayed 1 cycle; busy = 0.
REQ-035 Switch timing:
- Setup: GUARD=4; map_idx changes 4 -> 261 (idx_tab[1]=261) at edge T.
- Response: busy = 1 and map_out = safe_out from T+2 through T+5; at T+6 busy = 0, sel_ch = 1, map_out = map_in[1]; sw_cnt increments by 1.
REQ-036 Re-request in HOLD:
- Setup: map_idx goes 4 -> 261, then -> 290 (channel 2) two cycles later.
- Response: HOLD restarts and ends GUARD cycles after sel_ch = 2; sw_cnt +1 only.
REQ-037 No match:
- Setup: map_idx = 999, absent from idx_tab.
- Response: switch to channel 0 (nominal); sel_ch = 0 after HOLD.
REQ-038 Reset mid-HOLD:
- Setup: assert rst on the 2nd HOLD cycle.
- Response: next edge shows all REQ-031 values; sw_cnt stays 0.
REQ-039 Saturation:
- Setup: 300 alternating switches.
- Response: sw_cnt = 255; duplicate idx_tab entries in channels 2 and 5 select channel 2.
